// File: rtl/player_link_tx.sv
// Secondary-board control link: packs buttons, carry and player ID into an
// 11-bit UART-style frame (start, 8 data LSB first, even parity, stop).
module player_link_tx #(
  parameter int unsigned CLKS_PER_BIT   = 217,
  parameter int unsigned KEEPALIVE_CLKS = 416667
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  player_id,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic        chop,
  input  logic        carry,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned KA_W   = (KEEPALIVE_CLKS > 1) ? $clog2(KEEPALIVE_CLKS) : 1;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_FS = 16;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [KA_W-1:0]  KA_LAST  = KA_W'(KEEPALIVE_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic [DATA_W-1:0]   last_sent_q, last_sent_d;
  logic                first_pending_q, first_pending_d;
  logic [KA_W-1:0]     ka_cnt_q, ka_cnt_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [CNT_FS-1:0]   frames_q, frames_d;

  logic [DATA_W-1:0]   payload_c;
  logic                bit_end_c;
  logic                launch_c;

  assign payload_c = {player_id, carry, chop, up, down, left, right};
  assign bit_end_c = (bit_cnt_q == BIT_LAST);
  assign launch_c  = (state_q == S_IDLE) && enable &&
                     (first_pending_q || (payload_c != last_sent_q) || (ka_cnt_q == KA_LAST));

  // Next-state, shift register, keepalive and registered-output logic
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    bit_idx_d       = bit_idx_q;
    shreg_d         = shreg_q;
    parity_d        = parity_q;
    last_sent_d     = last_sent_q;
    first_pending_d = first_pending_q;
    ka_cnt_d        = ka_cnt_q;
    frames_d        = frames_q;
    tx_d            = 1'b1;
    busy_d          = 1'b0;

    if (state_q != S_IDLE) begin
      bit_cnt_d = bit_end_c ? '0 : bit_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (launch_c) begin
          state_d         = S_START;
          bit_cnt_d       = '0;
          shreg_d         = payload_c;
          parity_d        = ^payload_c;
          last_sent_d     = payload_c;
          first_pending_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          state_d  = S_IDLE;
          frames_d = frames_q + CNT_FS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Keepalive runs in every state; a launch restarts the interval
    if (!enable || launch_c) begin
      ka_cnt_d = '0;
    end else if (ka_cnt_q != KA_LAST) begin
      ka_cnt_d = ka_cnt_q + KA_W'(1);
    end

    // Line level for the upcoming cycle follows the state being entered
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      bit_idx_q       <= '0;
      shreg_q         <= '0;
      parity_q        <= 1'b0;
      last_sent_q     <= '0;
      first_pending_q <= 1'b1;
      ka_cnt_q        <= '0;
      tx_q            <= 1'b1;
      busy_q          <= 1'b0;
      frames_q        <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shreg_q         <= shreg_d;
      parity_q        <= parity_d;
      last_sent_q     <= last_sent_d;
      first_pending_q <= first_pending_d;
      ka_cnt_q        <= ka_cnt_d;
      tx_q            <= tx_d;
      busy_q          <= busy_d;
      frames_q        <= frames_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_player_link_tx.sv
// Bench for player_link_tx: frame-level model checked every cycle, plus
// directed scenarios with hand-computed frames, periods and counts.
module tb_player_link_tx;

  localparam int C  = 4;
  localparam int K  = 100;
  localparam int FL = 11 * C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  player_id;
  logic        left, right, up, down, chop, carry;
  logic        tx, busy;
  logic [15:0] frames_sent;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  player_link_tx #(.CLKS_PER_BIT(C), .KEEPALIVE_CLKS(K)) dut (
    .clock(clk), .reset_n(reset_n), .enable(enable), .player_id(player_id),
    .left(left), .right(right), .up(up), .down(down), .chop(chop), .carry(carry),
    .tx(tx), .busy(busy), .frames_sent(frames_sent)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Frame-level model: remaining line cycles of the current frame + launch rules
  int          m_rem = 0;
  logic [10:0] m_frame = '1;
  logic [7:0]  m_last = '0;
  bit          m_first = 1'b1;
  int          m_ka = 0;
  logic [15:0] m_frames = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] din;
    bit launched;
    cyc++;
    din = {player_id, carry, chop, up, down, left, right};
    launched = 1'b0;
    if (!reset_n) begin
      m_rem = 0; m_frames = '0; m_last = '0; m_first = 1'b1; m_ka = 0; m_valid = 1'b1;
    end else begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_frames++;
      end else if (enable && (m_first || din != m_last || m_ka == K - 1)) begin
        m_frame  = {1'b1, ^din, din, 1'b0};
        m_rem    = FL;
        m_last   = din;
        m_first  = 1'b0;
        launched = 1'b1;
      end
      if (!enable || launched) m_ka = 0;
      else if (m_ka < K - 1) m_ka++;
    end
  end

  always @(negedge clk) begin : compare
    logic exp_tx;
    if (m_valid) begin
      exp_tx = (m_rem > 0) ? m_frame[(FL - m_rem) / C] : 1'b1;
      chk("tx", 32'(tx), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("frames_sent", 32'(frames_sent), 32'(m_frames));
    end
  end

  task automatic do_act(input int act);
    case (act)
      1: chop = 1'b1;
      2: enable = 1'b0;
      3: reset_n = 1'b0;
      default: ;
    endcase
  endtask

  // Wait for a frame start, then sample the middle of each bit until busy drops
  task automatic capture(input int act_j, input int act, output logic [10:0] bits,
                         output int start_c, output int blen);
    int n = 0;
    int j = 0;
    bits = '1;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    while (busy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (busy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL capture_timeout: no frame start within %0d cycles", n);
    end
    start_c = cyc;
    while (busy === 1'b1 && j < 60) begin
      if (j % C == 1 && j < FL) bits[j / C] = tx;
      if (j == act_j) do_act(act);
      @(negedge clk);
      j++;
    end
    blen = j;
  endtask

  task automatic quiet_window(input int n, input bit toggle, output int bcnt);
    bcnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0) bcnt++;
      if (toggle) {left, right, up, down, chop} = 5'($urandom);
    end
  endtask

  initial begin
    logic [10:0] bits;
    int s1, s2, s3, s4, blen, bcnt;

    reset_n = 1'b0; enable = 1'b1; player_id = 2'd2; carry = 1'b0;
    left = 1'b1; right = 1'b0; up = 1'b0; down = 1'b0; chop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frames", 32'(frames_sent), 32'd0);
    reset_n = 1'b1;

    // Forced first frame: d=8'h82, P=0
    capture(-1, 0, bits, s1, blen);
    chk("f1_bits", 32'(bits), 32'h504);
    chk("f1_busy_len", 32'(blen), 32'd44);
    chk("f1_frames", 32'(frames_sent), 32'd1);

    // Keepalive with static inputs
    capture(-1, 0, bits, s2, blen);
    chk("ka_period", 32'(s2 - s1), 32'd100);
    chk("f2_bits", 32'(bits), 32'h504);
    chk("f2_frames", 32'(frames_sent), 32'd2);

    // chop rises during bit 4; current frame unaffected, next one follows 2 cycles after stop
    capture(17, 1, bits, s3, blen);
    chk("f3_bits", 32'(bits), 32'h504);
    chk("f3_period", 32'(s3 - s2), 32'd100);
    capture(-1, 0, bits, s4, blen);
    chk("f4_gap", 32'(s4 - s3), 32'd45);
    chk("f4_bits", 32'(bits), 32'h724);
    chk("f4_frames", 32'(frames_sent), 32'd4);

    // Disabled with toggling buttons: line stays idle
    enable = 1'b0;
    quiet_window(500, 1'b1, bcnt);
    chk("dis_busy_cycles", 32'(bcnt), 32'd0);
    chk("dis_frames", 32'(frames_sent), 32'd4);

    // Re-enable with d=8'h82, drop enable during DATA: frame completes
    {left, right, up, down, chop} = 5'b10000;
    enable = 1'b1;
    capture(10, 2, bits, s1, blen);
    chk("f5_bits", 32'(bits), 32'h504);
    chk("f5_busy_len", 32'(blen), 32'd44);
    chk("f5_frames", 32'(frames_sent), 32'd5);
    quiet_window(300, 1'b0, bcnt);
    chk("post_drop_busy", 32'(bcnt), 32'd0);
    chk("post_drop_frames", 32'(frames_sent), 32'd5);

    // Reset pulse during PARITY, then forced frame after release
    enable = 1'b1;
    capture(36, 3, bits, s1, blen);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_frames", 32'(frames_sent), 32'd0);
    reset_n = 1'b1;
    capture(-1, 0, bits, s1, blen);
    chk("f7_bits", 32'(bits), 32'h504);
    chk("f7_frames", 32'(frames_sent), 32'd1);

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_link_tx.md
# player_link_tx

Serial transmitter that carries one secondary FPGA's controls to the primary FPGA (player 0), which runs `game_logic` for all players. It packs the debounced buttons, the carry switch and the local player ID into one UART-style frame on a single wire, resending on any input change and at a fixed keepalive rate. It runs in the 25 MHz `clock` domain next to the debouncers. Its output drives a PMOD pin to the primary's matching receiver.

## Interface
Parameters:
- `CLKS_PER_BIT`, 217, clock cycles per serial bit (115200 baud at 25 MHz); must be ≥ 2.
- `KEEPALIVE_CLKS`, 416667, maximum cycles between frame launches while enabled (60 Hz); must be > 11*`CLKS_PER_BIT`.

Ports:
- `clock`  in  1  system clock, 25 MHz; one clock domain.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  high when this board is a secondary (player ID ≠ 0).
- `player_id`  in  2  local player ID.
- `left`, `right`, `up`, `down`, `chop`  in  1 each  debounced buttons, active high.
- `carry`  in  1  carry switch.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line.
- `frames_sent`  out  16  count of completed frames; wraps to 0 after 16'hFFFF.

## Operation
- Payload byte `d[7:0]` = {`player_id`[1:0], `carry`, `chop`, `up`, `down`, `left`, `right`}. `d[0]` = `right`.
- Frame is 11 bits: start (0), `d[0]`..`d[7]` LSB first, even parity bit P = XOR of `d[7:0]`, stop (1).
- State machine:
  - IDLE: `tx`=1, `busy`=0.
  - START → DATA (8 bits, index 0..7) → PARITY → STOP → IDLE.
  - Each non-IDLE state holds for exactly `CLKS_PER_BIT` cycles.
- Launch condition, evaluated in IDLE only: `enable` && (`first_pending` || `d` ≠ `last_sent` || `ka_cnt` == `KEEPALIVE_CLKS`-1).
- On launch:
  - `d` is snapshotted into the shift register and into `last_sent`.
  - `first_pending` clears and `ka_cnt` resets to 0.
- `ka_cnt` increments every cycle while `enable` is high, in all states. It saturates at `KEEPALIVE_CLKS`-1 and holds at 0 while `enable` is low.
- Input changes during a frame do not alter it. They are detected at the next IDLE cycle.
- `enable` falling mid-frame: the frame completes normally, then no further launches.
- `frames_sent` increments on the last cycle of STOP.
- Reset values: state IDLE, `tx`=1, `busy`=0, `frames_sent`=0, `last_sent`=8'h00, `ka_cnt`=0, `first_pending`=1. The first frame after reset is therefore forced once `enable` is high.
- Reset asserted mid-frame: the next cycle shows `tx`=1 and `busy`=0 with all state at reset values. No partial stop bit is emitted.

## Timing
- Launch decided in IDLE at cycle t. At t+1, `tx`=0 (start bit) and `busy`=1. All outputs are registered.
- Bit k of the frame (k=0 start … 10 stop) occupies cycles t+1+k*`CLKS_PER_BIT` through t+(k+1)*`CLKS_PER_BIT`.
- `busy` falls, and the FSM is in IDLE, at t+11*`CLKS_PER_BIT`+1.
- Earliest next launch is the decision at that same cycle, so the next start bit is at t+11*`CLKS_PER_BIT`+2. Minimum line-high time between frames is `CLKS_PER_BIT`+1 cycles.
- Static inputs give a frame-launch period of exactly `KEEPALIVE_CLKS` cycles.
- Bit counter width is ⌈log2(`CLKS_PER_BIT`)⌉. The keepalive counter width is ⌈log2(`KEEPALIVE_CLKS`)⌉.

## Test plan
Bench uses `CLKS_PER_BIT`=4 and `KEEPALIVE_CLKS`=100.
- Reset: hold `reset_n`=0 for 3 cycles → `tx`=1, `busy`=0, `frames_sent`=0.
- Forced first frame: release reset with `enable`=1, `player_id`=2, `left`=1, all else 0 → `d`=8'h82, P=0. Line shows 0 \| 0,1,0,0,0,0,0,1 \| 0 \| 1 at 4 cycles per bit. `busy` is high for 44 cycles. `frames_sent`=1.
- Keepalive: keep inputs static → frame launches exactly 100 cycles apart, all carrying 8'h82. `frames_sent` increments once per frame.
- Change mid-frame: set `chop`=1 during bit 4 of a frame → current frame still carries 8'h82. The next start bit comes 2 cycles after the end of the previous frame's stop bit and carries 8'h92, P=1.
- Enable low: `enable`=0 with toggling buttons for 500 cycles → `tx` stays 1 and `frames_sent` is unchanged. Drop `enable` during DATA → that frame still completes all 11 bits.
- Reset mid-frame: pulse `reset_n`=0 for 1 cycle during PARITY → `tx`=1 and `busy`=0 the next cycle. The next frame is forced when `enable` is high after release.
